csa_tree_pipe: RTL and testbench

//  Parametrised pipelined carry-save reduction tree: compresses NUM_IN operands of WIDTH bits to a
//  sum/carry pair, mod 2^WIDTH. Successor to the fixed 3..7-input combinational CSA trees; any NUM_IN>=2,

---
 rtl/csa_tree_pipe.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_csa_tree_pipe.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : csa_tree_pipe
// Purpose  : Parametrised pipelined carry-save reduction tree. Compresses
//            NUM_IN operands of WIDTH bits into a sum/carry pair whose
//            modular sum (mod 2^WIDTH) equals the sum of all operands.
//            A pipeline register is placed after every LVL_PER_STG levels
//            of 3:2 compressors. Valid/ready handshake on both sides with
//            a synchronous flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        bits per operand and per output vector
//   NUM_IN       operand count (>= 2)
//   LVL_PER_STG  3:2 compressor levels between pipeline registers (>= 1)
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous clear of all pipeline valids
//   in_valid   in   operand bundle valid
//   in_ready   out  bundle accepted this cycle (independent of in_valid)
//   in_ops     in   operand k at [k*WIDTH +: WIDTH]
//   out_valid  out  sum/carry valid
//   out_ready  in   consumer accepts
//   out_sum    out  sum vector
//   out_carry  out  carry vector (pre-shifted, MSB carry dropped)
//   out_result out  (sum+carry) mod 2^WIDTH, only with CSA_TREE_FINAL_ADD_EN
// Configuration
//   CSA_TREE_FINAL_ADD_EN : adds one extra stage holding the final
//                           carry-propagate sum on out_result.
// ============================================================================
module csa_tree_pipe #(
    parameter int WIDTH       = 8,
    parameter int NUM_IN      = 7,
    parameter int LVL_PER_STG = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NUM_IN-1:0] in_ops,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sum,
    output logic [WIDTH-1:0]        out_carry
`ifdef CSA_TREE_FINAL_ADD_EN
    ,
    output logic [WIDTH-1:0]        out_result
`endif
);

    // ------------------------------------------------------------------------
    // Tree geometry. Every level groups its rows into triples, each triple
    // becomes two rows; leftover rows pass through. So n rows become
    // n - floor(n/3) rows per level.
    // ------------------------------------------------------------------------
    function automatic int f_rows(input int lv);
        int n;
        n = NUM_IN;
        for (int k = 0; k < lv; k++) begin
            n = n - n / 3;
        end
        return n;
    endfunction

    function automatic int f_levels(input int n_in);
        int n;
        int l;
        n = n_in;
        l = 0;
        for (int k = 0; k < 64; k++) begin
            if (n > 2) begin
                n = n - n / 3;
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int c_levels      = f_levels(NUM_IN);
    localparam int c_tree_stages = (c_levels == 0) ? 1
                                 : (c_levels + LVL_PER_STG - 1) / LVL_PER_STG;

    // Number of compressor levels completed when data lands in stage i.
    function automatic int f_stage_end(input int i);
        return ((i + 1) * LVL_PER_STG < c_levels) ? (i + 1) * LVL_PER_STG : c_levels;
    endfunction

    // Bit offset of level-l input rows inside the flat node bus.
    function automatic int f_noff(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) begin
            o = o + f_rows(k) * WIDTH;
        end
        return o;
    endfunction

    // Bit offset of the rows produced by level l-1 (l >= 1) in the flat
    // compressor-output bus.
    function automatic int f_coff(input int l);
        int o;
        o = 0;
        for (int k = 1; k < l; k++) begin
            o = o + f_rows(k) * WIDTH;
        end
        return o;
    endfunction

    // Bit offset of stage i inside the flat pipeline data register.
    function automatic int f_soff(input int i);
        int o;
        o = 0;
        for (int j = 0; j < i; j++) begin
            o = o + f_rows(f_stage_end(j)) * WIDTH;
        end
        return o;
    endfunction

    localparam int c_stg_w    = f_soff(c_tree_stages);
    localparam int c_last_off = f_soff(c_tree_stages - 1);

`ifdef CSA_TREE_FINAL_ADD_EN
    localparam int c_stages = c_tree_stages + 1;
`else
    localparam int c_stages = c_tree_stages;
`endif

    // ------------------------------------------------------------------------
    // Handshake chain
    // ------------------------------------------------------------------------
    logic [c_stages-1:0] r_valid;
    logic [c_stages-1:0] w_vnext;
    logic [c_stages-1:0] w_load;   // stage takes new content (or a bubble)
    logic [c_stages-1:0] w_adv;    // stage content moves on
    logic [c_stages-1:0] w_xfer;   // stage captures a valid bundle

    // Readiness ripples backwards from out_ready; in_valid never enters
    // this path, so in_ready has no combinational dependency on it.
    always_comb begin
        w_load = '0;
        w_adv  = '0;
        w_adv[c_stages-1] = out_ready;
        for (int i = c_stages - 1; i >= 0; i--) begin
            w_load[i] = ~r_valid[i] | w_adv[i];
            if (i > 0) begin
                w_adv[i-1] = w_load[i];
            end
        end
    end

    assign in_ready = w_load[0] & ~flush;

    always_comb begin
        w_xfer    = '0;
        w_vnext   = r_valid;
        w_xfer[0] = in_valid & in_ready;
        if (w_load[0]) begin
            w_vnext[0] = in_valid;
        end
        for (int i = 1; i < c_stages; i++) begin
            w_xfer[i] = w_load[i] & r_valid[i-1] & ~flush;
            if (w_load[i]) begin
                w_vnext[i] = r_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_vnext;
        end
    end

    // ------------------------------------------------------------------------
    // Compressor network and stage data registers. Stage segments are packed
    // into one flat register; a per-bit enable mask loads only the stages
    // that receive a valid bundle this cycle.
    // ------------------------------------------------------------------------
    logic [c_stg_w-1:0] r_data;
    logic [c_stg_w-1:0] w_stage_d;
    logic [c_stg_w-1:0] w_mask;

    generate
        if (c_levels == 0) begin : g_passthru
            // Two operands are already a sum/carry pair.
            assign w_stage_d = in_ops;
        end else begin : g_tree
            localparam int c_node_w = f_noff(c_levels);
            localparam int c_cmp_w  = f_coff(c_levels + 1);

            logic [c_node_w-1:0] w_node;
            logic [c_cmp_w-1:0]  w_cmp;

            for (genvar l = 0; l < c_levels; l++) begin : g_level
                localparam int c_n   = f_rows(l);
                localparam int c_grp = c_n / 3;
                localparam int c_ni  = f_noff(l);
                localparam int c_co  = f_coff(l + 1);

                // Level input: the operands, a stage register at a stage
                // boundary, or the previous level's combinational output.
                if (l == 0) begin : g_src_in
                    assign w_node[c_ni +: c_n*WIDTH] = in_ops;
                end else if ((l % LVL_PER_STG) == 0) begin : g_src_reg
                    assign w_node[c_ni +: c_n*WIDTH] =
                        r_data[f_soff(l / LVL_PER_STG - 1) +: c_n*WIDTH];
                end else begin : g_src_comb
                    assign w_node[c_ni +: c_n*WIDTH] = w_cmp[f_coff(l) +: c_n*WIDTH];
                end

                for (genvar k = 0; k < c_grp; k++) begin : g_csa
                    logic [WIDTH-1:0] w_a;
                    logic [WIDTH-1:0] w_b;
                    logic [WIDTH-1:0] w_c;
                    logic [WIDTH-1:0] w_maj;
                    assign w_a   = w_node[c_ni + (3*k)*WIDTH   +: WIDTH];
                    assign w_b   = w_node[c_ni + (3*k+1)*WIDTH +: WIDTH];
                    assign w_c   = w_node[c_ni + (3*k+2)*WIDTH +: WIDTH];
                    assign w_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
                    assign w_cmp[c_co + (2*k)*WIDTH   +: WIDTH] = w_a ^ w_b ^ w_c;
                    // Carry weight doubles; the top carry falls off mod 2^WIDTH.
                    assign w_cmp[c_co + (2*k+1)*WIDTH +: WIDTH] = w_maj << 1;
                end

                for (genvar k = 0; k < c_n - 3*c_grp; k++) begin : g_pass
                    assign w_cmp[c_co + (2*c_grp+k)*WIDTH +: WIDTH] =
                        w_node[c_ni + (3*c_grp+k)*WIDTH +: WIDTH];
                end
            end

            for (genvar i = 0; i < c_tree_stages; i++) begin : g_stage_d
                localparam int c_rows = f_rows(f_stage_end(i));
                assign w_stage_d[f_soff(i) +: c_rows*WIDTH] =
                    w_cmp[f_coff(f_stage_end(i)) +: c_rows*WIDTH];
            end
        end

        for (genvar i = 0; i < c_tree_stages; i++) begin : g_mask
            localparam int c_rows = f_rows(f_stage_end(i));
            assign w_mask[f_soff(i) +: c_rows*WIDTH] = {(c_rows*WIDTH){w_xfer[i]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= (w_mask & w_stage_d) | (~w_mask & r_data);
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_tsum;
    logic [WIDTH-1:0] w_tcarry;

    assign w_tsum   = r_data[c_last_off +: WIDTH];
    assign w_tcarry = r_data[c_last_off + WIDTH +: WIDTH];
    assign out_valid = r_valid[c_stages-1];

`ifdef CSA_TREE_FINAL_ADD_EN
    logic [WIDTH-1:0] r_fsum;
    logic [WIDTH-1:0] r_fcarry;
    logic [WIDTH-1:0] r_fres;

    // sum/carry are re-registered here so they stay aligned with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsum   <= '0;
            r_fcarry <= '0;
            r_fres   <= '0;
        end else if (w_xfer[c_stages-1]) begin
            r_fsum   <= w_tsum;
            r_fcarry <= w_tcarry;
            r_fres   <= w_tsum + w_tcarry;
        end
    end

    assign out_sum    = r_fsum;
    assign out_carry  = r_fcarry;
    assign out_result = r_fres;
`else
    assign out_sum   = w_tsum;
    assign out_carry = w_tcarry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_tree_pipe
// Purpose  : Self-checking bench for csa_tree_pipe. A default-parameter
//            instance runs directed and random traffic against a queue
//            scoreboard; three extra instances sweep NUM_IN / LVL_PER_STG.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_csa_tree_pipe;

    localparam int W   = 8;
    localparam int N   = 7;
    localparam int LPS = 2;

    logic             clk;
    logic             rst_n;
    logic             rst_sw;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W*N-1:0]   in_ops;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic [W-1:0]     out_carry;
`ifdef CSA_TREE_FINAL_ADD_EN
    logic [W-1:0]     out_result;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int s_main;

    // Main scoreboard
    int exp_q[$];
    int cyc_q[$];
    bit mon_en    = 0;
    bit lat_chk   = 0;
    bit hold_pend = 0;
    logic [W-1:0] prev_sum;
    logic [W-1:0] prev_carry;

    csa_tree_pipe #(.WIDTH(W), .NUM_IN(N), .LVL_PER_STG(LPS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
`ifdef CSA_TREE_FINAL_ADD_EN
        ,
        .out_result(out_result)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected latency from the tree-depth sequence 2,3,4,6,9,13,...
    function automatic int exp_stages(input int n, input int lps);
        int d;
        int l;
        int s;
        d = 2;
        l = 0;
        while (d < n) begin
            d = (3 * d) / 2;
            l++;
        end
        s = (l + lps - 1) / lps;
        if (s < 1) s = 1;
`ifdef CSA_TREE_FINAL_ADD_EN
        s = s + 1;
`endif
        return s;
    endfunction

    function automatic int ref_sum(input logic [W*N-1:0] v);
        int tot;
        tot = 0;
        for (int k = 0; k < N; k++) tot += int'(v[k*W +: W]);
        return tot % (1 << W);
    endfunction

    function automatic logic [W*N-1:0] rand_ops();
        logic [W*N-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    // Main monitor: ordering, values, latency, stall stability
    always @(negedge clk) begin : p_mon
        int e;
        int c0;
        int got;
        if (!rst_n) begin
            exp_q.delete();
            cyc_q.delete();
            hold_pend = 0;
        end else if (mon_en) begin
            if (hold_pend) begin
                check("stall_valid", out_valid, 1);
                check("stall_sum", out_sum, prev_sum);
                check("stall_carry", out_carry, prev_carry);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e   = exp_q.pop_front();
                    c0  = cyc_q.pop_front();
                    got = (int'(out_sum) + int'(out_carry)) % (1 << W);
                    check("sum_carry", got, e);
`ifdef CSA_TREE_FINAL_ADD_EN
                    check("result", out_result, e);
`endif
                    if (lat_chk) check("latency", cyc - c0, s_main);
                end
            end
            hold_pend  = out_valid && !out_ready && !flush;
            prev_sum   = out_sum;
            prev_carry = out_carry;
            if (flush) begin
                exp_q.delete();
                cyc_q.delete();
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(in_ops));
                cyc_q.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic [W*N-1:0] v);
        bit got;
        int b;
        in_ops   = v;
        in_valid = 1;
        b   = 0;
        got = 0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            b++;
        end while (!got && b < 100);
        in_valid = 0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Parameter sweep instances: continuous random traffic, out_ready high
    // ------------------------------------------------------------------------
    for (genvar s = 0; s < 3; s++) begin : g_sweep
        localparam int SN = (s == 0) ? 13 : (s == 1) ? 2 : 19;
        localparam int SL = (s == 0) ? 1 : 3;

        logic            sw_in_valid;
        logic            sw_in_ready;
        logic [W*SN-1:0] sw_ops;
        logic            sw_out_valid;
        logic [W-1:0]    sw_sum;
        logic [W-1:0]    sw_carry;
`ifdef CSA_TREE_FINAL_ADD_EN
        logic [W-1:0]    sw_res;
`endif
        bit sw_done = 0;
        int sq[$];
        int cq[$];
        int s_exp;

        csa_tree_pipe #(.WIDTH(W), .NUM_IN(SN), .LVL_PER_STG(SL)) u_sw (
            .clk       (clk),
            .rst_n     (rst_sw),
            .flush     (1'b0),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready),
            .in_ops    (sw_ops),
            .out_valid (sw_out_valid),
            .out_ready (1'b1),
            .out_sum   (sw_sum),
            .out_carry (sw_carry)
`ifdef CSA_TREE_FINAL_ADD_EN
            ,
            .out_result(sw_res)
`endif
        );

        initial begin
            sw_in_valid = 0;
            sw_ops      = '0;
            s_exp       = exp_stages(SN, SL);
            wait (rst_sw === 1'b1);
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                #1;
                for (int k = 0; k < SN; k++) sw_ops[k*W +: W] = W'($urandom_range(0, (1 << W) - 1));
                sw_in_valid = 1;
            end
            @(posedge clk);
            #1;
            sw_in_valid = 0;
            repeat (12) @(posedge clk);
            check("sw_drain", sq.size(), 0);
            sw_done = 1;
        end

        always @(negedge clk) begin : p_sw_mon
            int e;
            int c0;
            int tot;
            if (rst_sw) begin
                if (sw_out_valid) begin
                    if (sq.size() == 0) begin
                        check("sw_unexpected", 1, 0);
                    end else begin
                        e  = sq.pop_front();
                        c0 = cq.pop_front();
                        check("sw_sum_carry", (int'(sw_sum) + int'(sw_carry)) % (1 << W), e);
`ifdef CSA_TREE_FINAL_ADD_EN
                        check("sw_result", sw_res, e);
`endif
                        check("sw_latency", cyc - c0, s_exp);
                    end
                end
                if (sw_in_valid && sw_in_ready) begin
                    tot = 0;
                    for (int k = 0; k < SN; k++) tot += int'(sw_ops[k*W +: W]);
                    sq.push_back(tot % (1 << W));
                    cq.push_back(cyc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : p_main
        logic [W*N-1:0] v;
        int  k;
        bit  got;
        bit  done;

        s_main    = exp_stages(N, LPS);
        rst_n     = 0;
        rst_sw    = 0;
        flush     = 0;
        in_valid  = 0;
        in_ops    = '0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1;
        rst_sw = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_in_ready", in_ready, 1);
        mon_en = 1;
        @(posedge clk);
        #1;

        // Single bundle 1..7, exact latency
        lat_chk = 1;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i + 1);
        send(v);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        check("first_latency", k, s_main);
        check("first_value", (int'(out_sum) + int'(out_carry)) % 256, 28);
        drain("drain_basic");

        // All-ones wrap
        v = '1;
        send(v);
        drain("drain_wrap");

        // 1000 back-to-back random bundles, full throughput expected
        for (int i = 0; i < 1000; i++) begin
            in_ops   = rand_ops();
            in_valid = 1;
            @(negedge clk);
            check("throughput_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        drain("drain_random");
        lat_chk = 0;

        // Backpressure: 10 bundles with random out_ready
        done = 0;
        fork
            begin
                for (int b = 0; b < 10; b++) send(rand_ops());
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1;
        drain("drain_backpressure");

        // Flush a full, stalled pipe
        out_ready = 0;
        k   = 0;
        got = 1;
        while (got && k < 20) begin
            in_ops   = rand_ops();
            in_valid = 1;
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        check("flush_prefill_valid", out_valid, 1);
        flush = 1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 0;
        in_valid = 0;
        check("flush_out_valid", out_valid, 0);
        out_ready = 1;
        repeat (s_main + 2) @(posedge clk);
        #1;
        check("flush_no_ghost", out_valid, 0);
        send(rand_ops());
        drain("drain_after_flush");

        // Asynchronous reset mid-stream with a full, stalled pipe
        out_ready = 0;
        for (int b = 0; b < s_main; b++) send(rand_ops());
        check("pre_reset_valid", out_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_sum", out_sum, 0);
        check("async_rst_carry", out_carry, 0);
`ifdef CSA_TREE_FINAL_ADD_EN
        check("async_rst_result", out_result, 0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        out_ready = 1;
        @(posedge clk);
        #1;
        send(rand_ops());
        drain("drain_after_reset");

        // Wait for the sweep instances
        k = 0;
        while (!(g_sweep[0].sw_done && g_sweep[1].sw_done && g_sweep[2].sw_done) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("sweep_done", (g_sweep[0].sw_done && g_sweep[1].sw_done && g_sweep[2].sw_done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
